// File: rtl/uart_periph_if.sv
// CPU data-bus port of the UART peripheral: one request, one-cycle acknowledge
// with read data valid while mem_ready is high.
interface uart_periph_if;
    logic        mem_sel;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_sel, mem_valid, mem_wr, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_sel, mem_valid, mem_wr, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serial shifter, single-byte RX
// holding register, programmable clocks-per-bit divisor, level irq on rx_valid.
module uart_periph #(
    parameter int          TX_FIFO_DEPTH   = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
    input  logic         clk,
    input  logic         reset,
    uart_periph_if.slave bus,
    output logic         uart_txd,
    input  logic         uart_rxd,
    output logic         irq
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} line_state_e;
    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_DIVISOR, REG_RSVD} reg_e;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] read_mux;
    logic [15:0] divisor;
    logic [15:0] eff_div;
    reg_e        reg_sel;
    logic        access, rd_data, rd_status, wr_data, wr_div;

    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_busy, tx_tick;

    line_state_e tx_state;
    logic [15:0] tx_cnt, tx_bit_div;
    logic [2:0]  tx_bit_idx;
    logic [7:0]  tx_shreg;

    line_state_e rx_state;
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, rx_half_tick;
    logic [15:0] rx_cnt, rx_bit_div;
    logic [2:0]  rx_bit_idx;
    logic [7:0]  rx_shreg, rx_byte;
    logic        rx_valid, rx_overrun, rx_frame_err;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[11:4], bus.mem_addr[1:0], bus.mem_wdata[31:16]};

    assign reg_sel   = reg_e'(bus.mem_addr[3:2]);
    assign access    = bus.mem_valid & bus.mem_sel & ~ready_q;
    assign rd_data   = access & ~bus.mem_wr & (reg_sel == REG_DATA);
    assign rd_status = access & ~bus.mem_wr & (reg_sel == REG_STATUS);
    assign wr_data   = access &  bus.mem_wr & (reg_sel == REG_DATA);
    assign wr_div    = access &  bus.mem_wr & (reg_sel == REG_DIVISOR);
    assign eff_div   = (divisor < 16'd2) ? 16'd2 : divisor;

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign irq           = rx_valid;

    // NOTE: every branch of a combinational block must assign its outputs; the default first keeps it latch-free.
    always_comb begin
        read_mux = '0;
        case (reg_sel)
            REG_DATA:    read_mux = {rx_valid, 23'd0, rx_byte};
            REG_STATUS:  read_mux = {26'd0, rx_frame_err, rx_overrun, rx_valid,
                                     tx_busy, tx_empty, tx_full};
            REG_DIVISOR: read_mux = {16'd0, divisor};
            default:     read_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            divisor <= DEFAULT_DIVISOR;
        end else begin
            ready_q <= access;
            rdata_q <= (access && !bus.mem_wr) ? read_mux : 32'd0;
            if (wr_div) divisor <= bus.mem_wdata[15:0];
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_tick  = (tx_cnt == tx_bit_div - 16'd1);
    assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));
    assign tx_push  = wr_data && (!tx_full || tx_pop);
    assign tx_busy  = (tx_state != S_IDLE);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // ---------------------------------------------------------------- TX FSM
    // The line is registered from the current state, so it trails the FSM by one clock uniformly.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit_div <= DEFAULT_DIVISOR;
            tx_bit_idx <= '0;
            tx_shreg   <= '0;
            uart_txd   <= 1'b1;
        end else begin
            case (tx_state)
                S_START: uart_txd <= 1'b0;
                S_DATA:  uart_txd <= tx_shreg[0];
                default: uart_txd <= 1'b1;
            endcase

            if (tx_state == S_IDLE) begin
                if (tx_pop) begin
                    tx_shreg   <= fifo_mem[rd_ptr[AW-1:0]];
                    tx_state   <= S_START;
                    tx_cnt     <= '0;
                    tx_bit_div <= eff_div;
                end
            end else if (tx_tick) begin
                tx_cnt     <= '0;
                tx_bit_div <= eff_div;
                case (tx_state)
                    S_START: begin
                        tx_state   <= S_DATA;
                        tx_bit_idx <= '0;
                    end
                    S_DATA: begin
                        tx_shreg <= tx_shreg >> 1;
                        if (tx_bit_idx == 3'd7) tx_state <= S_STOP;
                        else                    tx_bit_idx <= tx_bit_idx + 3'd1;
                    end
                    default: begin
                        tx_state <= tx_pop ? S_START : S_IDLE;
                        if (tx_pop) tx_shreg <= fifo_mem[rd_ptr[AW-1:0]];
                    end
                endcase
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------- RX path
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall      = rx_prev & ~rx_s2;
    assign rx_tick      = (rx_cnt == rx_bit_div - 16'd1);
    assign rx_half_tick = (rx_cnt == (rx_bit_div >> 1) - 16'd1);

    // Read-side clears come first so a completing frame in the same cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit_div   <= DEFAULT_DIVISOR;
            rx_bit_idx   <= '0;
            rx_shreg     <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rd_data) rx_valid <= 1'b0;
            if (rd_status) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end

            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_state   <= S_START;
                        rx_cnt     <= '0;
                        rx_bit_div <= eff_div;
                    end
                end
                S_START: begin
                    if (rx_half_tick) begin
                        rx_cnt     <= '0;
                        rx_bit_div <= eff_div;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_cnt     <= '0;
                        rx_bit_div <= eff_div;
                        rx_shreg   <= {rx_s2, rx_shreg[7:1]};
                        if (rx_bit_idx == 3'd7) rx_state <= S_STOP;
                        else                    rx_bit_idx <= rx_bit_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                        if (!rx_s2) begin
                            rx_frame_err <= 1'b1;
                        end else if (!rx_valid || rd_data) begin
                            rx_byte  <= rx_shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule
